instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Front end of the MIPS pipeline; sits directly upstream of the synchronous-read instruction memory.
//  Owns the program counter and drives the memory address each cycle.
//  Realigns the 1-cycle memory read data with the PC that fetched it.
//  Presents {instr, pc, valid} to decode; handles stall, branch/jump redirect and bubble insertion.
// PARAMETERS
//  DATA_WIDTH  32            instruction width
//  ADDR_WIDTH  10            instruction-memory address width; imem_addr = pc[ADDR_WIDTH-1:0]
//  PC_WIDTH    32            program-counter width
//  RESET_PC    32'h000031B0  first fetch address after reset
// PORTS
//  clk            in   1           single clock, rising edge
//  rst            in   1           synchronous, active-high reset
//  imem_addr      out  ADDR_WIDTH  address to instruction memory (combinational)
//  imem_data      in   DATA_WIDTH  memory output; valid 1 cycle after imem_addr is sampled
//  stall          in   1           decode cannot accept; hold current output
//  redirect       in   1           branch/jump taken this cycle
//  redirect_pc    in   PC_WIDTH    redirect target byte address
//  if_instr       out  DATA_WIDTH  instruction to decode; 32'd0 (NOP) when if_valid=0
//  if_pc          out  PC_WIDTH    byte address of if_instr
//  if_valid       out  1           if_instr/if_pc meaningful
//  fetch_count    out  32          number of instructions delivered (wrapping)
//  misalign_err   out  1           sticky; redirect_pc[1:0]!=0 was seen
// BEHAVIOUR
//  - Registers: pc, pc_d1 (address in flight), v_d1 (in-flight valid), fetch_count, misalign_err.
//  - Reset (rst=1 at edge): pc=RESET_PC, pc_d1=0, v_d1=0, fetch_count=0, misalign_err=0.
//    Outputs therefore: if_valid=0, if_pc=0, if_instr=0.
//  - imem_addr = (stall && !redirect) ? pc_d1[ADDR_WIDTH-1:0] : pc[ADDR_WIDTH-1:0].
//    Stall re-reads the displayed instruction, so the registered memory output stays stable.
//  - Outputs: if_pc=pc_d1; if_valid=v_d1; if_instr = v_d1 ? imem_data : 32'd0.
//  - Latency: pc=P sampled in cycle n -> if_instr=mem[P], if_pc=P, if_valid=1 in cycle n+1.
//  - Priority per edge: rst > redirect > stall > run.
//    run:      pc<=pc+4 (wraps modulo 2^PC_WIDTH); pc_d1<=pc; v_d1<=1.
//    stall:    pc, pc_d1, v_d1 hold.
//    redirect: pc<=redirect_pc with [1:0] forced to 2'b00; v_d1<=0 (one bubble; the in-flight fetch is squashed).
//              Stall in the same cycle is ignored.
//  - fetch_count += 1 on every edge where if_valid=1 && !stall && !redirect, i.e. instruction accepted by decode.
//  - misalign_err <= 1 when redirect && redirect_pc[1:0]!=0; cleared only by rst.
//  - Back-to-back redirects: each squashes; if_valid stays 0 until 1 cycle after the last redirect.
//  - First cycle after rst release: if_valid=0, imem_addr=RESET_PC[ADDR_WIDTH-1:0].
//  - Reset mid-stall or mid-redirect: rst wins; all state returns to reset values next edge.
// STRUCTURE
//  - Shared package mips_pkg: RESET_PC, INSTR_BYTES=4, NOP=32'd0, PC_WIDTH.
//  - One sub-module, fetch_pc_reg: pc/pc_d1/v_d1 with priority next-PC mux.
//  - Counter and error flag stay in the top.
// TESTING
//  1. Reset then run 5 cycles, memory model mem[a]=a -> if_pc=31B0,31B4,31B8,31BC; if_valid from cycle 2; fetch_count=4.
//  2. Stall 3 cycles while if_pc=31B8 -> if_pc/if_instr held at 31B8; imem_addr=1B8; count frozen; resumes at 31BC.
//  3. redirect=1, redirect_pc=31D4 at if_pc=31C0 -> next cycle if_valid=0, if_instr=0; following cycle if_pc=31D4.
//  4. redirect and stall together, target 31EC -> redirect wins: bubble, then if_pc=31EC.
//  5. redirect_pc=31C2 -> pc=31C0 fetched, misalign_err=1 and stays 1 until rst.
//  6. redirect_pc=FFFFFFFC, run 2 -> if_pc=FFFFFFFC then 00000000; rst asserted mid-stall -> pc=31B0, if_valid=0, count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   RESET_PC     first fetch byte address after reset
//   INSTR_BYTES  byte stride between sequential instructions
//   NOP          instruction word presented to decode during bubbles
//   PC_WIDTH     architectural program-counter width
//   pc_sel_e     next-PC source selector used by fetch_pc_reg
//   is_misaligned  flags a byte address that is not word aligned
package mips_pkg;

    localparam int          PC_WIDTH    = 32;
    localparam logic [31:0] RESET_PC    = 32'h0000_31B0;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'd0;

    typedef enum logic [1:0] {
        PC_SEL_RUN      = 2'd0,
        PC_SEL_HOLD     = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

    function automatic logic is_misaligned(input logic [1:0] byte_offset);
        return (byte_offset != 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, its instruction memory and decode.
//   imem_addr/imem_data      synchronous-read instruction memory port
//   stall/redirect/redirect_pc  control from decode / branch resolution
//   if_instr/if_pc/if_valid  fetched instruction presented to decode
//   fetch_count/misalign_err status
// master = fetch unit side, slave = environment (memory + decode) side.
interface instruction_fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int PC_WIDTH   = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  stall;
    logic                  redirect;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [PC_WIDTH-1:0]   if_pc;
    logic                  if_valid;
    logic [31:0]           fetch_count;
    logic                  misalign_err;

    modport master (
        output imem_addr, if_instr, if_pc, if_valid, fetch_count, misalign_err,
        input  imem_data, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, if_instr, if_pc, if_valid, fetch_count, misalign_err,
        output imem_data, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/instruction_fetch_unit_pc_reg.sv
// fetch_pc_reg: program counter plus the address/valid of the fetch in flight.
//   clk, rst        clock, synchronous active-high reset
//   stall           hold everything
//   redirect        load redirect target, squash the in-flight fetch
//   redirect_word   redirect target with the byte offset already dropped
//   pc_addr         low bits of pc (next fetch address into memory)
//   pc_d1, v_d1     address and valid of the fetch whose data memory returns now
module fetch_pc_reg #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  ADDR_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = mips_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-3:0]   redirect_word,
    output logic [ADDR_WIDTH-1:0] pc_addr,
    output logic [PC_WIDTH-1:0]   pc_d1,
    output logic                  v_d1
);
    import mips_pkg::*;

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INSTR_BYTES);

    pc_sel_e             pc_sel_s;
    logic [PC_WIDTH-1:0] pc_d,    pc_q;
    logic [PC_WIDTH-1:0] pc_d1_d, pc_d1_q;
    logic                v_d1_d,  v_d1_q;

    // Next-PC source: redirect beats stall, stall beats sequential run.
    always_comb begin
        pc_sel_s = PC_SEL_RUN;
        if (redirect) begin
            pc_sel_s = PC_SEL_REDIRECT;
        end else if (stall) begin
            pc_sel_s = PC_SEL_HOLD;
        end else begin
            pc_sel_s = PC_SEL_RUN;
        end
    end

    // Next-state values for pc and the in-flight slot.
    always_comb begin
        pc_d    = pc_q;
        pc_d1_d = pc_d1_q;
        v_d1_d  = v_d1_q;
        case (pc_sel_s)
            PC_SEL_RUN: begin
                pc_d    = pc_q + PC_STEP;
                pc_d1_d = pc_q;
                v_d1_d  = 1'b1;
            end
            PC_SEL_HOLD: begin
                pc_d    = pc_q;
                pc_d1_d = pc_d1_q;
                v_d1_d  = v_d1_q;
            end
            PC_SEL_REDIRECT: begin
                // Target is forced word aligned; the fetch in flight is squashed.
                pc_d    = {redirect_word, 2'b00};
                pc_d1_d = pc_d1_q;
                v_d1_d  = 1'b0;
            end
            default: begin
                pc_d    = pc_q;
                pc_d1_d = pc_d1_q;
                v_d1_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            pc_d1_q <= {PC_WIDTH{1'b0}};
            v_d1_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc_d1_q <= pc_d1_d;
            v_d1_q  <= v_d1_d;
        end
    end

    assign pc_addr = pc_q[ADDR_WIDTH-1:0];
    assign pc_d1   = pc_d1_q;
    assign v_d1    = v_d1_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS front end in front of a synchronous-read
// instruction memory. Drives the memory address, realigns the 1-cycle read
// data with the PC that fetched it, and handles stall / redirect / bubbles.
//   clk, rst   clock, synchronous active-high reset
//   bus        instruction_fetch_unit_if master: imem_addr/imem_data,
//              stall, redirect, redirect_pc, if_instr/if_pc/if_valid,
//              fetch_count (accepted instructions), misalign_err (sticky)
module instruction_fetch_unit #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 10,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = mips_pkg::RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
);
    import mips_pkg::*;

    logic [ADDR_WIDTH-1:0] pc_addr_s;
    logic [PC_WIDTH-1:0]   pc_d1_s;
    logic                  v_d1_s;
    logic [31:0]           fetch_count_d, fetch_count_q;
    logic                  misalign_err_d, misalign_err_q;

    fetch_pc_reg #(
        .PC_WIDTH   (PC_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .stall         (bus.stall),
        .redirect      (bus.redirect),
        .redirect_word (bus.redirect_pc[PC_WIDTH-1:2]),
        .pc_addr       (pc_addr_s),
        .pc_d1         (pc_d1_s),
        .v_d1          (v_d1_s)
    );

    // Memory address: while stalled re-read the displayed instruction so the
    // registered memory output keeps presenting it.
    always_comb begin
        if (bus.stall && !bus.redirect) begin
            bus.imem_addr = pc_d1_s[ADDR_WIDTH-1:0];
        end else begin
            bus.imem_addr = pc_addr_s;
        end
    end

    // Decode-side outputs; NOP whenever the slot is a bubble.
    always_comb begin
        if (v_d1_s) begin
            bus.if_instr = bus.imem_data;
        end else begin
            bus.if_instr = DATA_WIDTH'(NOP);
        end
    end

    assign bus.if_pc    = pc_d1_s;
    assign bus.if_valid = v_d1_s;

    // Status next-state: count accepted instructions, latch misaligned redirects.
    always_comb begin
        fetch_count_d  = fetch_count_q;
        misalign_err_d = misalign_err_q;
        if (v_d1_s && !bus.stall && !bus.redirect) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
        if (bus.redirect && is_misaligned(bus.redirect_pc[1:0])) begin
            misalign_err_d = 1'b1;
        end else begin
            misalign_err_d = misalign_err_q;
        end
    end

    // Status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q  <= 32'd0;
            misalign_err_q <= 1'b0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign bus.fetch_count  = fetch_count_q;
    assign bus.misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios then random
// stall/redirect/reset traffic, checked against a behavioural model.
module tb_instruction_fetch_unit;

    logic clk;
    logic rst;

    instruction_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .PC_WIDTH(32)) bus ();

    instruction_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: distinct word per address.
    function automatic logic [31:0] memfun(input logic [9:0] a);
        return {6'h2B, a, 6'h15, ~a};
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) bus.imem_data <= memfun(bus.imem_addr);

    typedef struct {
        logic [9:0]  addr;
        logic        valid;
        logic        pc_known;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] count;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int tests  = 0;
    int failed = 0;

    // Reference model state: next fetch address, displayed slot, status.
    logic [31:0] m_pc;
    logic [31:0] m_dpc;
    logic        m_dvalid;
    logic        m_dpc_known;
    logic [31:0] m_count;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the expectation for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
            chk("if_valid", 32'(bus.if_valid), 32'(e.valid));
            if (e.pc_known) chk("if_pc", bus.if_pc, e.pc);
            chk("if_instr", bus.if_instr, e.instr);
            chk("fetch_count", bus.fetch_count, e.count);
            chk("misalign_err", 32'(bus.misalign_err), 32'(e.err));
        end
    end

    task automatic model_reset();
        m_pc        = 32'h0000_31B0;
        m_dpc       = 32'd0;
        m_dvalid    = 1'b0;
        m_dpc_known = 1'b1;
        m_count     = 32'd0;
        m_err       = 1'b0;
    endtask

    // One clock: drive inputs, predict this cycle's outputs, then advance model.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        exp_t e;
        rst             = r;
        bus.stall       = s;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        e.addr     = (s && !rd) ? m_dpc[9:0] : m_pc[9:0];
        e.valid    = m_dvalid;
        e.pc_known = m_dpc_known;
        e.pc       = m_dpc;
        e.instr    = m_dvalid ? memfun(m_dpc[9:0]) : 32'd0;
        e.count    = m_count;
        e.err      = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (m_dvalid && !s && !rd) m_count = m_count + 32'd1;
            if (rd && rpc[1:0] != 2'b00) m_err = 1'b1;
            if (rd) begin
                m_pc        = rpc & 32'hFFFF_FFFC;
                m_dvalid    = 1'b0;
                m_dpc_known = 1'b0;
            end else if (!s) begin
                m_dpc       = m_pc;
                m_dvalid    = 1'b1;
                m_dpc_known = 1'b1;
                m_pc        = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Sequential run from RESET_PC.
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 32'd0);
        // Stall holds the displayed instruction and count.
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'd0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'd0);
        // Redirect: one bubble then target.
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_31D4);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0);
        // Redirect together with stall: redirect wins.
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_31EC);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'd0);
        // Misaligned target: aligned fetch, sticky error.
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_31C2);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0);
        // Back-to-back redirects.
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_3200);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_3210);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'd0);
        // PC wrap at top of address space.
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0);
        // Reset mid-stall.
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, rd;
            logic [31:0] rpc;
            int          mode;
            r    = ($urandom_range(0, 149) == 0);
            s    = ($urandom_range(0, 3) == 0);
            rd   = ($urandom_range(0, 7) == 0);
            mode = $urandom_range(0, 9);
            if (mode < 6)      rpc = 32'h0000_3000 + ($urandom_range(0, 255) << 2);
            else if (mode < 8) rpc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            else               rpc = $urandom;
            cyc(r, s, rd, rpc);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
